// File: rtl/ws2812_write_sched.sv
// Write-side scheduler: round-robin share of the ws2812 LED-buffer write port between host writes and a range-fill engine.
// Optional per-channel brightness scaling is enabled with `define WS2812_BRIGHTNESS_EN.
module ws2812_write_sched #(
  parameter int NUM_LEDS = 40
) (
  input  logic        i_clk,
  input  logic        i_reset,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]  i_brightness,
`endif
  input  logic        i_host_valid,
  output logic        o_host_ready,
  input  logic [7:0]  i_host_led,
  input  logic [23:0] i_host_rgb,
  output logic        o_host_err,
  input  logic        i_fill_start,
  input  logic [7:0]  i_fill_first,
  input  logic [7:0]  i_fill_last,
  input  logic [23:0] i_fill_rgb,
  output logic        o_fill_busy,
  output logic        o_fill_done,
  output logic        o_fill_err,
  output logic [23:0] o_led_rgb,
  output logic [7:0]  o_led_num,
  output logic        o_led_write
);

  localparam logic [8:0] LP_NUM_LEDS = 9'(NUM_LEDS);

  typedef enum logic {ST_IDLE = 1'b0, ST_FILL = 1'b1} state_t;
  typedef enum logic {GNT_HOST = 1'b0, GNT_FILL = 1'b1} grant_t;

`ifdef WS2812_BRIGHTNESS_EN
  function automatic logic [23:0] scale_rgb(input logic [23:0] rgb, input logic [7:0] br);
    logic [15:0] prod;
    scale_rgb = 24'h000000;
    for (int c = 0; c < 3; c++) begin
      prod = 16'(rgb[c*8 +: 8]) * 16'(br);
      scale_rgb[c*8 +: 8] = prod[15:8];
    end
  endfunction
`endif

  state_t      r_state;
  state_t      w_next_state;
  grant_t      r_last_grant;
  logic [7:0]  r_cursor;
  logic [7:0]  r_fill_last;
  logic [23:0] r_fill_rgb;
  logic        r_led_write;
  logic [7:0]  r_led_num;
  logic [23:0] r_led_rgb;
  logic        r_host_err;
  logic        r_fill_busy;
  logic        r_fill_done;
  logic        r_fill_err;

  logic        w_host_ready;
  logic        w_host_gnt;
  logic        w_fill_gnt;
  logic        w_host_led_ok;
  logic        w_fill_range_ok;
  logic        w_fill_load;
  logic        w_fill_last_wr;
  logic        w_wr;
  logic [7:0]  w_num;
  logic [23:0] w_src_rgb;
  logic [23:0] w_out_rgb;

  // Arbitration, fill control and next-state decode
  always_comb begin
    w_next_state    = r_state;
    w_host_ready    = !i_reset && ((r_state != ST_FILL) || (r_last_grant == GNT_FILL));
    w_host_gnt      = i_host_valid && w_host_ready;
    w_fill_gnt      = (r_state == ST_FILL) && !w_host_gnt;
    w_host_led_ok   = ({1'b0, i_host_led} < LP_NUM_LEDS);
    w_fill_range_ok = (i_fill_first <= i_fill_last) && ({1'b0, i_fill_last} < LP_NUM_LEDS);
    w_fill_load     = 1'b0;
    w_fill_last_wr  = w_fill_gnt && (r_cursor == r_fill_last);
    w_wr            = 1'b0;
    w_num           = r_led_num;
    w_src_rgb       = r_fill_rgb;
    case (r_state)
      ST_IDLE: begin
        if (i_fill_start && w_fill_range_ok) begin
          w_fill_load  = 1'b1;
          w_next_state = ST_FILL;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (w_fill_last_wr) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_FILL;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (w_host_gnt) begin
      w_wr      = w_host_led_ok;
      w_num     = i_host_led;
      w_src_rgb = i_host_rgb;
    end else if (w_fill_gnt) begin
      w_wr      = 1'b1;
      w_num     = r_cursor;
      w_src_rgb = r_fill_rgb;
    end else begin
      w_wr      = 1'b0;
    end
`ifdef WS2812_BRIGHTNESS_EN
    w_out_rgb = scale_rgb(w_src_rgb, i_brightness);
`else
    w_out_rgb = w_src_rgb;
`endif
  end

  // State register and round-robin history
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GNT_FILL;
    end else begin
      r_state <= w_next_state;
      if (w_host_gnt) begin
        r_last_grant <= GNT_HOST;
      end else if (w_fill_gnt) begin
        r_last_grant <= GNT_FILL;
      end
    end
  end

  // Fill range registers; cursor advances once per granted fill write
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cursor    <= 8'd0;
      r_fill_last <= 8'd0;
      r_fill_rgb  <= 24'h000000;
    end else if (w_fill_load) begin
      r_cursor    <= i_fill_first;
      r_fill_last <= i_fill_last;
      r_fill_rgb  <= i_fill_rgb;
    end else if (w_fill_gnt) begin
      r_cursor    <= r_cursor + 8'd1;
    end
  end

  // Registered driver port and status pulses; led_rgb/led_num hold when nothing is written
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_led_write <= 1'b0;
      r_led_num   <= 8'd0;
      r_led_rgb   <= 24'h000000;
      r_host_err  <= 1'b0;
      r_fill_busy <= 1'b0;
      r_fill_done <= 1'b0;
      r_fill_err  <= 1'b0;
    end else begin
      r_led_write <= w_wr;
      if (w_wr) begin
        r_led_num <= w_num;
        r_led_rgb <= w_out_rgb;
      end
      r_host_err  <= w_host_gnt && !w_host_led_ok;
      r_fill_busy <= (w_next_state == ST_FILL);
      r_fill_done <= w_fill_last_wr;
      r_fill_err  <= (r_state == ST_IDLE) && i_fill_start && !w_fill_range_ok;
    end
  end

  assign o_host_ready = w_host_ready;
  assign o_host_err   = r_host_err;
  assign o_fill_busy  = r_fill_busy;
  assign o_fill_done  = r_fill_done;
  assign o_fill_err   = r_fill_err;
  assign o_led_rgb    = r_led_rgb;
  assign o_led_num    = r_led_num;
  assign o_led_write  = r_led_write;

endmodule

// File: tb/tb_ws2812_write_sched.sv
// Scoreboard bench for ws2812_write_sched: a queue-based reference model predicts each cycle's outputs, a monitor compares.
module tb_ws2812_write_sched;
  localparam int NUM = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_valid;
  logic        host_ready;
  logic [7:0]  host_led;
  logic [23:0] host_rgb;
  logic        host_err;
  logic        fill_start;
  logic [7:0]  fill_first;
  logic [7:0]  fill_last;
  logic [23:0] fill_rgb;
  logic        fill_busy;
  logic        fill_done;
  logic        fill_err;
  logic [23:0] led_rgb;
  logic [7:0]  led_num;
  logic        led_write;

  ws2812_write_sched #(.NUM_LEDS(NUM)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_host_valid(host_valid), .o_host_ready(host_ready),
    .i_host_led(host_led), .i_host_rgb(host_rgb), .o_host_err(host_err),
    .i_fill_start(fill_start), .i_fill_first(fill_first), .i_fill_last(fill_last),
    .i_fill_rgb(fill_rgb), .o_fill_busy(fill_busy), .o_fill_done(fill_done),
    .o_fill_err(fill_err), .o_led_rgb(led_rgb), .o_led_num(led_num), .o_led_write(led_write)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [7:0]  num;
    logic [23:0] rgb;
    logic        herr;
    logic        fdone;
    logic        ferr;
    logic        busy;
  } rec_t;

  rec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state: pending fill LEDs as a plain list
  int          fill_q[$];
  logic [23:0] m_fill_rgb = 24'h0;
  bit          m_last_fill = 1'b1;
  logic [7:0]  m_num = 8'h0;
  logic [23:0] m_rgb = 24'h0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Applies one cycle of inputs, predicts host_ready now and all registered outputs for the next cycle.
  task automatic step(input bit rst, input bit hv, input int hl, input logic [23:0] hr,
                      input bit fs, input int ff, input int fl, input logic [23:0] fr);
    rec_t r;
    bit busy_before, rdy, hg;
    @(negedge clk);
    reset = rst; host_valid = hv; host_led = 8'(hl); host_rgb = hr;
    fill_start = fs; fill_first = 8'(ff); fill_last = 8'(fl); fill_rgb = fr;
    #1;
    r.cyc = cyc + 1; r.wr = 1'b0; r.herr = 1'b0; r.fdone = 1'b0; r.ferr = 1'b0;
    if (rst) begin
      chk("host_ready_in_reset", 32'(host_ready), 32'd0);
      fill_q.delete();
      m_last_fill = 1'b1; m_num = 8'h0; m_rgb = 24'h0;
    end else begin
      busy_before = (fill_q.size() > 0);
      rdy = !(busy_before && !m_last_fill);
      chk("host_ready", 32'(host_ready), 32'(rdy));
      hg = hv && rdy;
      if (hg) begin
        m_last_fill = 1'b0;
        if (hl < NUM) begin
          r.wr = 1'b1; m_num = 8'(hl); m_rgb = hr;
        end else begin
          r.herr = 1'b1;
        end
      end else if (busy_before) begin
        m_last_fill = 1'b1;
        r.wr = 1'b1; m_num = 8'(fill_q.pop_front()); m_rgb = m_fill_rgb;
        if (fill_q.size() == 0) r.fdone = 1'b1;
      end
      if (fs && !busy_before) begin
        if (ff <= fl && fl < NUM) begin
          for (int i = ff; i <= fl; i++) fill_q.push_back(i);
          m_fill_rgb = fr;
        end else begin
          r.ferr = 1'b1;
        end
      end
    end
    r.num = m_num; r.rgb = m_rgb; r.busy = (fill_q.size() > 0);
    sb.push_back(r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 24'h0, 0, 0, 0, 24'h0);
  endtask

  // Monitor: pops the prediction for each cycle in which the DUT outputs are valid
  initial begin
    rec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("cycle_tag", 32'(cyc), 32'(e.cyc));
        chk("led_write", 32'(led_write), 32'(e.wr));
        chk("led_num", 32'(led_num), 32'(e.num));
        chk("led_rgb", 32'(led_rgb), 32'(e.rgb));
        chk("host_err", 32'(host_err), 32'(e.herr));
        chk("fill_done", 32'(fill_done), 32'(e.fdone));
        chk("fill_err", 32'(fill_err), 32'(e.ferr));
        chk("fill_busy", 32'(fill_busy), 32'(e.busy));
      end
    end
  end

  initial begin
    int a, b;
    reset = 1'b1; host_valid = 1'b0; host_led = 8'h0; host_rgb = 24'h0;
    fill_start = 1'b0; fill_first = 8'h0; fill_last = 8'h0; fill_rgb = 24'h0;
    step(1, 0, 0, 24'h0, 0, 0, 0, 24'h0);
    step(1, 0, 0, 24'h0, 0, 0, 0, 24'h0);
    idle(5);
    // single host write
    step(0, 1, 7, 24'h112233, 0, 0, 0, 24'h0);
    idle(2);
    // short fill, host idle
    step(0, 0, 0, 24'h0, 1, 2, 5, 24'h00FF00);
    idle(7);
    // full fill under continuous host contention
    step(0, 1, 9, 24'hABCDEF, 1, 0, 39, 24'h123456);
    for (int i = 0; i < 84; i++) step(0, 1, 9, 24'hABCDEF, 0, 0, 0, 24'h0);
    idle(3);
    // illegal ranges and out-of-range host LED
    step(0, 0, 0, 24'h0, 1, 5, 3, 24'hFFFFFF);
    idle(2);
    step(0, 0, 0, 24'h0, 1, 3, 40, 24'hFFFFFF);
    idle(2);
    step(0, 1, 40, 24'h445566, 0, 0, 0, 24'h0);
    idle(2);
    // reset in the 3rd cycle of a fill, then a single-LED fill
    step(0, 0, 0, 24'h0, 1, 0, 39, 24'h0000FF);
    idle(1);
    step(1, 0, 0, 24'h0, 0, 0, 0, 24'h0);
    idle(1);
    step(0, 0, 0, 24'h0, 1, 0, 0, 24'h777777);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      a = $urandom_range(0, 45);
      b = $urandom_range(0, 45);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 1) == 1), $urandom_range(0, 45),
           24'($urandom), ($urandom_range(0, 19) == 0), a, b, 24'($urandom));
    end
    idle(4);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
